// File: rtl/dac_sample_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dac_pkg
// Brief    : Shared types and constants for the DAC sample FIFO.
// Revision : 1.0
// ============================================================================
package dac_pkg;

    localparam int DEF_DAC_WIDTH = 10;

    localparam logic [DEF_DAC_WIDTH-1:0] MIDSCALE = {1'b1, {(DEF_DAC_WIDTH-1){1'b0}}};

    // Bit offsets of the I and Q fields inside a packed software write word
    localparam int I_LSB = 0;
    localparam int Q_LSB = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/dac_sample_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : dac_fifo_ram
// Brief    : Simple dual-port RAM, synchronous write, registered read-first.
// Revision : 1.0
// ============================================================================
module dac_fifo_ram #(
    parameter int AW = 6,
    parameter int DW = 20
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd_data_q;

    // Read data only moves on a read strobe, so it can serve as the held output
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/dac_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dac_sample_fifo
// Brief    : Paced I/Q sample FIFO feeding the DAC core over valid/ready.
//            Optional replay mode enabled by macro DAC_FIFO_LOOP_EN.
// Revision : 1.0
// ============================================================================
module dac_sample_fifo
    import dac_pkg::*;
#(
    parameter int DAC_WIDTH = DEF_DAC_WIDTH,
    parameter int FIFO_AW   = 6,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 SPLB_Clk,
    input  logic                 SPLB_Rst_n,
    input  logic                 Wr_En,
    input  logic [31:0]          Wr_Data,
    output logic                 Wr_Full,
    input  logic                 Enable,
    input  logic                 Flush,
    input  logic [DIV_WIDTH-1:0] Rate_Div,
    input  logic                 Err_Clr,
    output logic [DAC_WIDTH-1:0] Smp_I,
    output logic [DAC_WIDTH-1:0] Smp_Q,
    output logic                 Smp_Valid,
    input  logic                 Smp_Ready,
`ifdef DAC_FIFO_LOOP_EN
    input  logic                 Loop_Mode,
`endif
    output logic [FIFO_AW:0]     Fill_Level,
    output logic                 Underrun,
    output logic                 Overflow
);

    localparam int                    c_RAM_W    = 2 * DAC_WIDTH;
    localparam logic [DAC_WIDTH-1:0]  c_MIDSCALE = {1'b1, {(DAC_WIDTH-1){1'b0}}};
    localparam logic [FIFO_AW:0]      c_DEPTH    = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]      c_HALF     = {2'b01, {(FIFO_AW-1){1'b0}}};

    state_e                state_q, state_d;
    logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]      level_q, level_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic                  valid_q, valid_d;
    logic                  mid_q, mid_d;
    logic                  unr_q, unr_d;
    logic                  ovf_q, ovf_d;
    logic                  loop_q;

    logic                  w_loop;
    logic [FIFO_AW-1:0]    w_diff;
    logic [FIFO_AW-1:0]    w_oldest;
    logic [FIFO_AW-1:0]    w_newest;
    logic [FIFO_AW:0]      w_lvl;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_out_free;
    logic                  w_tick;
    logic                  w_pop;
    logic                  w_consume;
    logic                  w_unr_evt;
    logic                  w_push;
    logic                  w_ovf_evt;
    logic [c_RAM_W-1:0]    w_ram_wdata;
    logic [c_RAM_W-1:0]    w_ram_rdata;
    logic                  w_unused;

`ifdef DAC_FIFO_LOOP_EN
    assign w_loop = Loop_Mode;
`else
    assign w_loop = 1'b0;
`endif

    // Level is frozen while replaying; on leaving replay it is rebuilt from the
    // pointer distance. A zero distance can only mean completely empty or full.
    assign w_diff = wr_ptr_q - rd_ptr_q;

    always_comb begin
        w_lvl = level_q;
        if (loop_q && !w_loop && (w_diff != '0)) begin
            w_lvl = {1'b0, w_diff};
        end
    end

    assign w_empty    = (w_lvl == '0);
    assign w_full     = (w_lvl == c_DEPTH);
    assign Wr_Full    = w_full || w_loop;
    assign w_out_free = !valid_q || Smp_Ready;
    assign w_tick     = (state_q == RUN) && Enable && (cnt_q == div_q) && !Flush;
    assign w_pop      = w_tick && w_out_free && !w_empty;
    assign w_unr_evt  = w_tick && w_out_free && w_empty;
    assign w_consume  = w_pop && !w_loop;
    assign w_push     = Wr_En && !Flush && !w_loop && (!w_full || w_consume);
    assign w_ovf_evt  = Wr_En && !Flush && !w_loop && w_full && !w_consume;
    assign w_oldest   = wr_ptr_q - level_q[FIFO_AW-1:0];
    assign w_newest   = wr_ptr_q - FIFO_AW'(1);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = w_lvl;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (w_pop) begin
            if (w_loop && (rd_ptr_q == w_newest)) begin
                rd_ptr_d = w_oldest;
            end else begin
                rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
            end
        end
        if (w_push && !w_consume) begin
            level_d = w_lvl + (FIFO_AW+1)'(1);
        end else if (!w_push && w_consume) begin
            level_d = w_lvl - (FIFO_AW+1)'(1);
        end
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (Enable) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                cnt_d = '0;
                if (!Enable) begin
                    state_d = IDLE;
                end else if ((w_lvl >= c_HALF) || Wr_Full) begin
                    state_d = RUN;
                    div_d   = Rate_Div;
                end
            end
            RUN: begin
                if (!Enable) begin
                    // Let a presented pair finish its handshake before stopping
                    if (!(valid_q && !Smp_Ready)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == div_q) begin
                    cnt_d = '0;
                    div_d = Rate_Div;
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (Flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        valid_d = valid_q && !Smp_Ready;
        mid_d   = mid_q;
        if (w_pop) begin
            valid_d = 1'b1;
            mid_d   = 1'b0;
        end else if (w_unr_evt) begin
            valid_d = 1'b1;
            mid_d   = 1'b1;
        end
        if (Flush) begin
            valid_d = 1'b0;
        end
        unr_d = (unr_q && !Err_Clr) || w_unr_evt;
        ovf_d = (ovf_q && !Err_Clr) || w_ovf_evt;
    end

    always_ff @(posedge SPLB_Clk or negedge SPLB_Rst_n) begin
        if (!SPLB_Rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            div_q    <= '0;
            valid_q  <= 1'b0;
            mid_q    <= 1'b1;
            unr_q    <= 1'b0;
            ovf_q    <= 1'b0;
            loop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            valid_q  <= valid_d;
            mid_q    <= mid_d;
            unr_q    <= unr_d;
            ovf_q    <= ovf_d;
            loop_q   <= w_loop;
        end
    end

    assign w_ram_wdata = {Wr_Data[Q_LSB +: DAC_WIDTH], Wr_Data[I_LSB +: DAC_WIDTH]};
    assign w_unused    = ^Wr_Data;

    dac_fifo_ram #(
        .AW (FIFO_AW),
        .DW (c_RAM_W)
    ) u_ram (
        .clk       (SPLB_Clk),
        .wr_en_i   (w_push),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (w_ram_wdata),
        .rd_en_i   (w_pop),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (w_ram_rdata)
    );

    assign Smp_I      = mid_q ? c_MIDSCALE : w_ram_rdata[DAC_WIDTH-1:0];
    assign Smp_Q      = mid_q ? c_MIDSCALE : w_ram_rdata[c_RAM_W-1:DAC_WIDTH];
    assign Smp_Valid  = valid_q;
    assign Fill_Level = level_q;
    assign Underrun   = unr_q;
    assign Overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_sample_fifo
// Brief    : Self-checking bench for dac_sample_fifo with a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_dac_sample_fifo;

    localparam logic [19:0] MID_PAIR = {10'h200, 10'h200};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] rate_div = '0;
    logic        err_clr = 1'b0;
    logic        smp_ready = 1'b0;
    logic        wr_full;
    logic [9:0]  smp_i;
    logic [9:0]  smp_q;
    logic        smp_valid;
    logic [6:0]  fill;
    logic        underrun;
    logic        overflow;
`ifdef DAC_FIFO_LOOP_EN
    logic        loop_mode = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    logic [19:0] model[$];

    always #5 clk = ~clk;

    dac_sample_fifo dut (
        .SPLB_Clk   (clk),
        .SPLB_Rst_n (rst_n),
        .Wr_En      (wr_en),
        .Wr_Data    (wr_data),
        .Wr_Full    (wr_full),
        .Enable     (enable),
        .Flush      (flush),
        .Rate_Div   (rate_div),
        .Err_Clr    (err_clr),
        .Smp_I      (smp_i),
        .Smp_Q      (smp_q),
        .Smp_Valid  (smp_valid),
        .Smp_Ready  (smp_ready),
`ifdef DAC_FIFO_LOOP_EN
        .Loop_Mode  (loop_mode),
`endif
        .Fill_Level (fill),
        .Underrun   (underrun),
        .Overflow   (overflow)
    );

    // Software write; the model keeps at most 64 words like a real 64-deep buffer
    task automatic push_word(input logic [31:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        @(negedge clk);
        wr_en   = 1'b0;
        if (model.size() < 64) model.push_back({w[25:16], w[9:0]});
    endtask

    task automatic push_random(input int n);
        logic [31:0] d;
        for (int k = 0; k < n; k++) begin
            d = $urandom;
            push_word(d);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        err_clr = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        err_clr = 1'b0;
        model.delete();
    endtask

    // Observes the next accepted pair; pr = {Q,I}, waited = negedges elapsed
    task automatic wait_pair(input int budget, output logic [19:0] pr,
                             output int waited, output bit ok);
        ok = 1'b0;
        waited = 0;
        pr = '0;
        while (!ok && waited < budget) begin
            @(negedge clk);
            waited++;
            if (smp_valid && smp_ready) begin
                ok = 1'b1;
                pr = {smp_q, smp_i};
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_chk++; if (smp_valid !== 1'b0) $display("FAIL rst_hold_valid: got %0b expected 0", smp_valid); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (smp_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", smp_valid); else n_pass++;
        n_chk++; if ({smp_q, smp_i} !== MID_PAIR) $display("FAIL reset_iq: got %0h expected %0h", {smp_q, smp_i}, MID_PAIR); else n_pass++;
        n_chk++; if (fill !== 7'd0) $display("FAIL reset_fill: got %0d expected 0", fill); else n_pass++;
        n_chk++; if ({wr_full, underrun, overflow} !== 3'b000) $display("FAIL reset_flags: got %0b expected 000", {wr_full, underrun, overflow}); else n_pass++;
    endtask

    task automatic test_prime_pace();
        logic [31:0] d;
        logic [19:0] pr;
        logic [19:0] exp_pr;
        int w;
        bit ok;
        for (int n = 0; n < 32; n++) begin
            d = $urandom;
            d[9:0] = n[9:0];
            d[25:16] = 10'h3FF - n[9:0];
            push_word(d);
        end
        n_chk++; if (fill !== 7'd32) $display("FAIL prime_fill: got %0d expected 32", fill); else n_pass++;
        rate_div = 16'd3;
        smp_ready = 1'b1;
        enable = 1'b1;
        for (int n = 0; n < 32; n++) begin
            wait_pair(20, pr, w, ok);
            exp_pr = model.pop_front();
            n_chk++; if (!ok || pr !== exp_pr) $display("FAIL pace_pair%0d: got %0h expected %0h", n, pr, exp_pr); else n_pass++;
            if (n > 0) begin
                n_chk++; if (w != 4) $display("FAIL pace_period%0d: got %0d expected 4", n, w); else n_pass++;
            end
        end
        n_chk++; if (fill !== 7'd0) $display("FAIL pace_fill_end: got %0d expected 0", fill); else n_pass++;
        wait_pair(20, pr, w, ok);
        n_chk++; if (!ok || pr !== MID_PAIR || w != 4) $display("FAIL underrun_pair: got %0h after %0d expected %0h after 4", pr, w, MID_PAIR); else n_pass++;
        n_chk++; if (underrun !== 1'b1) $display("FAIL underrun_flag: got %0b expected 1", underrun); else n_pass++;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_chk++; if (underrun !== 1'b0) $display("FAIL underrun_clear: got %0b expected 0", underrun); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [19:0] pr;
        logic [19:0] exp_pr;
        int w;
        bit ok;
        do_flush();
        push_random(65);
        n_chk++; if (fill !== 7'd64) $display("FAIL ovf_fill: got %0d expected 64", fill); else n_pass++;
        n_chk++; if (wr_full !== 1'b1) $display("FAIL ovf_full: got %0b expected 1", wr_full); else n_pass++;
        n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %0b expected 1", overflow); else n_pass++;
        wr_en = 1'b1;
        wr_data = $urandom;
        err_clr = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        err_clr = 1'b0;
        n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins: got %0b expected 1", overflow); else n_pass++;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_chk++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %0b expected 0", overflow); else n_pass++;
        rate_div = 16'd0;
        smp_ready = 1'b1;
        enable = 1'b1;
        for (int n = 0; n < 64; n++) begin
            wait_pair(10, pr, w, ok);
            exp_pr = model.pop_front();
            n_chk++; if (!ok || pr !== exp_pr) $display("FAIL ovf_drain%0d: got %0h expected %0h", n, pr, exp_pr); else n_pass++;
        end
        wait_pair(10, pr, w, ok);
        n_chk++; if (!ok || pr !== MID_PAIR) $display("FAIL ovf_word65_dropped: got %0h expected %0h", pr, MID_PAIR); else n_pass++;
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [19:0] pr;
        logic [19:0] held;
        logic [19:0] exp_pr;
        int w;
        int guard;
        bit ok;
        do_flush();
        push_random(40);
        rate_div = 16'd0;
        smp_ready = 1'b0;
        enable = 1'b1;
        guard = 0;
        while (!smp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_chk++; if (smp_valid !== 1'b1) $display("FAIL bp_first_valid: got %0b expected 1", smp_valid); else n_pass++;
        held = {smp_q, smp_i};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_chk++; if (smp_valid !== 1'b1 || {smp_q, smp_i} !== held) $display("FAIL bp_hold%0d: got %0b/%0h expected 1/%0h", k, smp_valid, {smp_q, smp_i}, held); else n_pass++;
            n_chk++; if (fill !== 7'(model.size() - 1)) $display("FAIL bp_fill%0d: got %0d expected %0d", k, fill, model.size() - 1); else n_pass++;
        end
        smp_ready = 1'b1;
        exp_pr = model.pop_front();
        n_chk++; if (held !== exp_pr) $display("FAIL bp_held_pair: got %0h expected %0h", held, exp_pr); else n_pass++;
        for (int n = 0; n < 39; n++) begin
            wait_pair(10, pr, w, ok);
            exp_pr = model.pop_front();
            n_chk++; if (!ok || pr !== exp_pr) $display("FAIL bp_drain%0d: got %0h expected %0h", n, pr, exp_pr); else n_pass++;
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_flush();
        logic [19:0] pr;
        logic [19:0] exp_pr;
        int w;
        int seen;
        bit ok;
        do_flush();
        push_random(40);
        rate_div = 16'd5;
        smp_ready = 1'b1;
        enable = 1'b1;
        wait_pair(30, pr, w, ok);
        exp_pr = model.pop_front();
        n_chk++; if (!ok || pr !== exp_pr) $display("FAIL flush_first: got %0h expected %0h", pr, exp_pr); else n_pass++;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model.delete();
        n_chk++; if (fill !== 7'd0 || smp_valid !== 1'b0) $display("FAIL flush_clear: got fill %0d valid %0b expected 0/0", fill, smp_valid); else n_pass++;
        flush = 1'b1;
        wr_en = 1'b1;
        wr_data = $urandom;
        @(negedge clk);
        flush = 1'b0;
        wr_en = 1'b0;
        n_chk++; if (fill !== 7'd0 || overflow !== 1'b0) $display("FAIL flush_vs_write: got fill %0d ovf %0b expected 0/0", fill, overflow); else n_pass++;
        push_random(4);
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (smp_valid) seen++;
        end
        n_chk++; if (seen != 0 || underrun !== 1'b0) $display("FAIL flush_to_idle: got %0d valids unr %0b expected 0/0", seen, underrun); else n_pass++;
        n_chk++; if (fill !== 7'd4) $display("FAIL flush_refill: got %0d expected 4", fill); else n_pass++;
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

`ifdef DAC_FIFO_LOOP_EN
    task automatic test_loop();
        logic [19:0] pr;
        logic [19:0] ring[4];
        int w;
        bit ok;
        do_flush();
        push_random(4);
        for (int k = 0; k < 4; k++) ring[k] = model[k];
        rate_div = 16'($urandom_range(0, 3));
        smp_ready = 1'b1;
        loop_mode = 1'b1;
        enable = 1'b1;
        for (int n = 0; n < 12; n++) begin
            wait_pair(30, pr, w, ok);
            n_chk++; if (!ok || pr !== ring[n % 4]) $display("FAIL loop_pair%0d: got %0h expected %0h", n, pr, ring[n % 4]); else n_pass++;
            n_chk++; if (fill !== 7'd4 || wr_full !== 1'b1) $display("FAIL loop_level%0d: got %0d/%0b expected 4/1", n, fill, wr_full); else n_pass++;
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        loop_mode = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid();
        logic [19:0] pr;
        int w;
        bit ok;
        do_flush();
        push_random(40);
        rate_div = 16'd0;
        smp_ready = 1'b1;
        enable = 1'b1;
        wait_pair(20, pr, w, ok);
        rst_n = 1'b0;
        #1;
        n_chk++; if (smp_valid !== 1'b0 || {smp_q, smp_i} !== MID_PAIR) $display("FAIL midrst_out: got %0b/%0h expected 0/%0h", smp_valid, {smp_q, smp_i}, MID_PAIR); else n_pass++;
        n_chk++; if (fill !== 7'd0 || wr_full !== 1'b0) $display("FAIL midrst_fill: got %0d/%0b expected 0/0", fill, wr_full); else n_pass++;
        enable = 1'b0;
        model.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_prime_pace();
        test_overflow();
        test_backpressure();
        test_flush();
`ifdef DAC_FIFO_LOOP_EN
        test_loop();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/dac_sample_fifo.md
Name: dac_sample_fifo

Overview:
- Upstream sample source for the plb_dac DAC core.
- Buffers packed I/Q sample words written by software through the PLB slave IPIC write path.
- Releases one I/Q pair every Rate_Div+1 clocks to the DAC core over a valid/ready handshake.
- Handles priming, underrun/overflow reporting and flush, so software streaming is decoupled from the DAC conversion rate.

Parameters:
- DAC_WIDTH, 10, bits per I and Q sample; must match the DAC core.
- FIFO_AW, 6, log2 of FIFO depth (64 entries).
- DIV_WIDTH, 16, width of the sample-rate divider.

Ports:
- SPLB_Clk  in  1  sole clock.
- SPLB_Rst_n  in  1  asynchronous, active-low reset.
- Wr_En  in  1  push strobe, one word per cycle.
- Wr_Data  in  32  I = [DAC_WIDTH-1:0], Q = [16+DAC_WIDTH-1:16]; other bits ignored.
- Wr_Full  out  1  FIFO full.
- Enable  in  1  playback enable (level).
- Flush  in  1  synchronous FIFO/pacer clear (pulse).
- Rate_Div  in  DIV_WIDTH  sample period minus one, in clocks.
- Err_Clr  in  1  clears sticky flags.
- Smp_I  out  DAC_WIDTH  I sample to DAC core.
- Smp_Q  out  DAC_WIDTH  Q sample to DAC core.
- Smp_Valid  out  1  sample pair valid.
- Smp_Ready  in  1  DAC core accepts pair.
- Fill_Level  out  FIFO_AW+1  stored entries, 0..2^FIFO_AW.
- Underrun  out  1  sticky.
- Overflow  out  1  sticky.

Behaviour:
- Reset values:
  - FIFO empty; Fill_Level = 0; Wr_Full = 0.
  - Smp_I = Smp_Q = MIDSCALE (1<<(DAC_WIDTH-1)); Smp_Valid = 0.
  - Underrun = Overflow = 0; state IDLE; divider counter = 0.
- Write side:
  - Wr_En while not full: stores the word; Fill_Level increments on the next cycle.
  - Wr_En while full with no pop that cycle: word dropped, Overflow set.
  - Push and pop in the same cycle: both take effect; level is unchanged.
  - Push into an empty FIFO: no bypass; the word is poppable one cycle later.
- State machine:
  - IDLE: Smp_Valid = 0, counter held at 0. Enable=1 → PRIME.
  - PRIME: waits until Fill_Level >= 2^(FIFO_AW-1) or Wr_Full, then → RUN with counter = 0. Enable=0 → IDLE.
  - RUN: counter counts 0..Rate_Div and wraps; a tick occurs when counter == Rate_Div. Rate_Div = 0 gives a tick every cycle.
- On a tick, if the output register is free (Smp_Valid=0, or Smp_Valid & Smp_Ready in the same cycle):
  - FIFO not empty: pop; Smp_I/Smp_Q updated and Smp_Valid=1 on the next cycle.
  - FIFO empty: Underrun set; output loaded with MIDSCALE, Smp_Valid=1.
- Tick while the output register is still held (Smp_Valid & !Smp_Ready): tick discarded, no pop, no flag.
- Smp_I/Smp_Q are stable while Smp_Valid & !Smp_Ready. Smp_Valid drops the cycle after acceptance unless a new tick reloads it.
- Enable=0 in RUN: any pending valid pair completes its handshake, then → IDLE. FIFO contents are retained; the last sample values stay on Smp_I/Q.
- Flush: same cycle, pointers and level cleared, counter = 0, Smp_Valid = 0, state → IDLE. Flush wins over a simultaneous Wr_En (word dropped, no Overflow). Sticky flags unaffected.
- Err_Clr: clears both stickies. A simultaneous set event wins (flag stays 1).
- Rate_Div changes take effect at the next counter wrap.
- Reset asserted mid-operation: all state returns to reset values immediately.

Optional Feature:
- DAC_FIFO_LOOP_EN defined:
  - Adds input Loop_Mode (1 bit).
  - Loop_Mode=1 in RUN: pops read without freeing entries. The read pointer wraps from the newest entry back to the oldest, so the buffer replays cyclically.
  - Fill_Level is constant in loop mode; Wr_Full forced 1; writes dropped without Overflow; Underrun only occurs if the buffer is empty.
  - Leaving Loop_Mode resumes normal consumption from the current read position.
- Not defined: Loop_Mode port absent; FIFO always consumes on pop.

Decomposition:
- Package dac_pkg:
  - DAC_WIDTH default.
  - MIDSCALE constant.
  - State enum {IDLE, PRIME, RUN}.
  - Wr_Data field offsets (I_LSB=0, Q_LSB=16).
- Sub-module dac_fifo_ram: simple dual-port RAM, 2^FIFO_AW x 2*DAC_WIDTH, synchronous write, registered read.
- Pointers, level, pacer and FSM stay in dac_sample_fifo.

Test Plan:
- Reset then idle: Smp_Valid=0, Smp_I=Smp_Q=0x200, Fill_Level=0.
- Prime/pace: write 32 words (I=n, Q=0x3FF-n), Enable=1, Rate_Div=3, Smp_Ready=1 → pairs 0..31 in order, Smp_Valid pulses every 4 clocks, Fill_Level ends 0.
- Underrun: after the 32 pairs drain, the next tick outputs 0x200/0x200 valid and Underrun=1; Err_Clr → 0.
- Overflow: 65 writes with Enable=0 → Wr_Full=1, Fill_Level=64, Overflow=1, 65th word never output.
- Backpressure: Rate_Div=0, Smp_Ready low 5 cycles → Smp_I/Q held, no pops, Fill_Level unchanged.
- Flush plus loop mode:
  - Flush mid-RUN → Fill_Level=0, Smp_Valid=0 next cycle, state IDLE.
  - With DAC_FIFO_LOOP_EN: 4 words, Loop_Mode=1 → output 0,1,2,3,0,1,… with Fill_Level=4.
